rx_data_receive: RTL
====================

RX_DATA_RECEIVE -- requirements
Module: rx_data_receive

Interface
REQ-001 pclk_rx  in  1  receive-side system clock; all state on rising edge.
REQ-002 enable_rx  in  1  asynchronous active-low reset; low clears all state immediately.
REQ-003 link_run  in  1  link state machine in Run; low means disconnected or not started.
REQ-004 rx_got_nchar  in  1  one-cycle strobe: decoder delivered an N-char.
REQ-005 rx_nchar  in  9  N-char; [8]=0 data byte, 9'h100 EOP, 9'h101 EEP.
REQ-006 rx_got_time  in  1  one-cycle strobe: decoder delivered a time-code.
REQ-007 rx_time  in  8  time-code; [7:6] control flags, [5:0] time value.
REQ-008 fifo_free  in  7  free host RX FIFO slots, 0..64.
REQ-009 fct_sent  in  1  one-cycle strobe from transmitter: one FCT transmitted.
REQ-010 rx_data_o  out  9  N-char presented to host FIFO.
REQ-011 rxwrite_rx  out  1  one-cycle host FIFO write strobe qualifying rx_data_o.
REQ-012 fct_req  out  1  level request to transmitter to send one FCT.
REQ-013 rx_credit  out  6  outstanding credit granted to the far end, 0..56.
REQ-014 credit_error  out  1  sticky: N-char received with zero credit.
REQ-015 timecode_rx_o  out  8  last received time-code.
REQ-016 tickout_rx  out  1  one-cycle strobe: valid sequential time-code received.

Function
REQ-017 States SHALL be WAIT_RUN, IDLE, IN_PKT, INSERT_EEP.
REQ-018 WAIT_RUN->IDLE when link_run=1; any state->WAIT_RUN when link_run=0, except IN_PKT->INSERT_EEP.
REQ-019 IDLE->IN_PKT on an accepted data N-char; IN_PKT->IDLE on an accepted EOP or EEP.
REQ-020 INSERT_EEP SHALL write 9'h101 with rxwrite_rx=1 for exactly one cycle, then go to WAIT_RUN.
REQ-021 Accepted N-char (rx_got_nchar=1, rx_credit>0, state IDLE/IN_PKT, link_run=1): rx_data_o<=rx_nchar and rxwrite_rx=1 on the next cycle (latency 1).
REQ-022 Each accepted N-char SHALL decrement rx_credit by 1.
REQ-023 N-char arriving with rx_credit=0 SHALL be dropped and credit_error set; credit_error holds until reset.
REQ-024 fct_req=1 when state IDLE/IN_PKT, rx_credit<=48, and fifo_free>=rx_credit+8 (7-bit compare, no overflow); otherwise 0; registered.
REQ-025 fct_sent SHALL add 8 to rx_credit; fct_sent while rx_credit>48 is ignored (saturation guard, credit unchanged).
REQ-026 Simultaneous fct_sent and accepted N-char: rx_credit<=rx_credit+7.
REQ-027 link_run=0: rx_credit cleared to 0 next cycle, fct_req=0, incoming N-chars and time-codes discarded.
REQ-028 link_run falling in the same cycle as rx_got_nchar: link drop wins, char discarded.
REQ-029 rx_got_time: timecode_rx_o<=rx_time always; tickout_rx=1 next cycle only if rx_time[5:0]==(timecode_rx_o[5:0]+1) mod 64.
REQ-030 Time value wrap 63->0 SHALL count as sequential; identical or skipped values give no tick.
REQ-031 Time-code and N-char strobes in the same cycle SHALL both be processed independently.

Reset
REQ-032 enable_rx low: state WAIT_RUN, rx_data_o=9'd0, rxwrite_rx=0, fct_req=0, rx_credit=0, credit_error=0, timecode_rx_o=8'd0, tickout_rx=0.
REQ-033 Reset mid-packet SHALL NOT generate an EEP; deassertion is synchronised to pclk_rx before leaving WAIT_RUN.

Structure
REQ-034 Shared package spw_rx_defs SHALL hold EOP/EEP codes, FCT_CREDIT=8, CREDIT_MAX=56, CREDIT_REQ_LIMIT=48, state encodings.
REQ-035 Time-code sequence check and register SHALL be sub-module rx_timecode_check; all else in rx_data_receive.

Verification
REQ-036 link_run=1, fifo_free=64, three fct_sent -> rx_credit=24, fct_req stays 1 until credit 56 is reached.
REQ-037 Credit 8, send 8'h11..8'h18 then 9'h100 -> 8 writes with rx_data_o matching each 1 cycle later, EOP dropped, credit_error=1.
REQ-038 Credit 16, data 8'hA5 then link_run=0 -> writes 9'h0A5 then 9'h101, rx_credit=0, state WAIT_RUN.
REQ-039 Time-codes 6'd62, 63, 0, 0, 5 -> tickout_rx on 63 and first 0 only; timecode_rx_o=8'h05 at end.
REQ-040 Credit 10, fct_sent with rx_got_nchar same cycle -> rx_credit=17; fifo_free=20 with credit 17 -> fct_req=0.

Source files
------------

// File: rtl/spw_rx_defs.sv
// ---------------------------------------------------------------------------
// spw_rx_defs
// Shared definitions for the SpaceWire receive data path: control N-char
// codes, flow-control credit constants, and the receive FSM state encoding.
// ---------------------------------------------------------------------------
package spw_rx_defs;

    // Control N-chars: bit 8 set marks a control character
    localparam logic [8:0] NCHAR_EOP = 9'h100;
    localparam logic [8:0] NCHAR_EEP = 9'h101;

    // Flow control: one FCT grants 8 N-chars of credit, at most 56 outstanding
    localparam logic [5:0] FCT_CREDIT       = 6'd8;
    localparam logic [5:0] CREDIT_MAX       = 6'd56;
    localparam logic [5:0] CREDIT_REQ_LIMIT = 6'd48;

    typedef enum logic [1:0] {
        WAIT_RUN   = 2'd0,
        IDLE       = 2'd1,
        IN_PKT     = 2'd2,
        INSERT_EEP = 2'd3
    } rx_state_e;

    // EOP and EEP both terminate a packet
    function automatic logic is_pkt_end(input logic [8:0] nchar);
        return nchar[8];
    endfunction

    // States in which N-chars are accepted and credit may be requested
    function automatic logic is_link_state(input rx_state_e st);
        return (st == IDLE) || (st == IN_PKT);
    endfunction

endpackage

// File: rtl/rx_timecode_check.sv
// ---------------------------------------------------------------------------
// rx_timecode_check
// Holds the last received time-code and raises a one-cycle tick when the new
// time value is the previous value plus one (modulo 64).
//   pclk_rx        in   receive clock
//   enable_rx      in   async active-low reset
//   time_en        in   time-codes are accepted only while high (link running)
//   rx_got_time    in   strobe: time-code delivered
//   rx_time        in   [7:6] flags, [5:0] time value
//   timecode_rx_o  out  last accepted time-code
//   tickout_rx     out  strobe: sequential time-code accepted
// ---------------------------------------------------------------------------
module rx_timecode_check (
    input  logic       pclk_rx,
    input  logic       enable_rx,
    input  logic       time_en,
    input  logic       rx_got_time,
    input  logic [7:0] rx_time,
    output logic [7:0] timecode_rx_o,
    output logic       tickout_rx
);

    logic [7:0] tc_q, tc_d;
    logic       tick_q, tick_d;
    logic [5:0] next_val;

    always_comb begin
        // 6-bit add wraps 63 -> 0, so the wrap counts as sequential
        next_val = tc_q[5:0] + 6'd1;
        tc_d     = tc_q;
        tick_d   = 1'b0;
        if (rx_got_time && time_en) begin
            tc_d   = rx_time;
            tick_d = (rx_time[5:0] == next_val);
        end
    end

    always_ff @(posedge pclk_rx or negedge enable_rx) begin
        if (!enable_rx) begin
            tc_q   <= 8'd0;
            tick_q <= 1'b0;
        end else begin
            tc_q   <= tc_d;
            tick_q <= tick_d;
        end
    end

    assign timecode_rx_o = tc_q;
    assign tickout_rx    = tick_q;

endmodule

// File: rtl/rx_data_receive.sv
// ---------------------------------------------------------------------------
// rx_data_receive
// Receive-side data path: forwards decoded N-chars to the host FIFO under
// credit control, requests FCTs, terminates an open packet with EEP on link
// loss, and tracks time-codes.
//   pclk_rx        in   receive clock
//   enable_rx      in   async active-low reset
//   link_run       in   link state machine is in Run
//   rx_got_nchar   in   strobe: N-char from decoder
//   rx_nchar       in   N-char (9'h100 EOP, 9'h101 EEP)
//   rx_got_time    in   strobe: time-code from decoder
//   rx_time        in   time-code
//   fifo_free      in   free host FIFO slots (0..64)
//   fct_sent       in   strobe: transmitter sent one FCT
//   rx_data_o      out  N-char to host FIFO
//   rxwrite_rx     out  host FIFO write strobe
//   fct_req        out  request one FCT
//   rx_credit      out  outstanding credit (0..56)
//   credit_error   out  sticky: N-char received without credit
//   timecode_rx_o  out  last time-code
//   tickout_rx     out  strobe: sequential time-code
// ---------------------------------------------------------------------------
module rx_data_receive
    import spw_rx_defs::*;
(
    input  logic       pclk_rx,
    input  logic       enable_rx,
    input  logic       link_run,
    input  logic       rx_got_nchar,
    input  logic [8:0] rx_nchar,
    input  logic       rx_got_time,
    input  logic [7:0] rx_time,
    input  logic [6:0] fifo_free,
    input  logic       fct_sent,
    output logic [8:0] rx_data_o,
    output logic       rxwrite_rx,
    output logic       fct_req,
    output logic [5:0] rx_credit,
    output logic       credit_error,
    output logic [7:0] timecode_rx_o,
    output logic       tickout_rx
);

    rx_state_e  state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic [8:0] data_q, data_d;
    logic       write_q, write_d;
    logic       fct_req_q, fct_req_d;
    logic [5:0] credit_q, credit_d;
    logic       err_q, err_d;

    logic       active;
    logic       accept;
    logic       fct_ok;

    always_comb begin
        // Reset release is brought into the clock domain before the FSM may
        // leave WAIT_RUN
        sync_d = {sync_q[0], 1'b1};

        active = is_link_state(state_q) && link_run;
        accept = rx_got_nchar && active && (credit_q != 6'd0);
        // Guard keeps credit from ever exceeding CREDIT_MAX
        fct_ok = fct_sent && link_run && (credit_q <= CREDIT_MAX - FCT_CREDIT);

        state_d = state_q;
        case (state_q)
            WAIT_RUN:   if (link_run && sync_q[1]) state_d = IDLE;
            IDLE: begin
                if (!link_run)                              state_d = WAIT_RUN;
                else if (accept && !is_pkt_end(rx_nchar))   state_d = IN_PKT;
            end
            IN_PKT: begin
                if (!link_run)                              state_d = INSERT_EEP;
                else if (accept && is_pkt_end(rx_nchar))    state_d = IDLE;
            end
            INSERT_EEP: state_d = WAIT_RUN;
            default:    state_d = WAIT_RUN;
        endcase

        if (!link_run)
            credit_d = 6'd0;
        else
            credit_d = credit_q + (fct_ok ? FCT_CREDIT : 6'd0) - {5'd0, accept};

        // Link loss inside a packet wins over any N-char in that cycle
        data_d  = data_q;
        write_d = 1'b0;
        if (state_q == IN_PKT && !link_run) begin
            data_d  = NCHAR_EEP;
            write_d = 1'b1;
        end else if (accept) begin
            data_d  = rx_nchar;
            write_d = 1'b1;
        end

        err_d = err_q | (rx_got_nchar && active && (credit_q == 6'd0));

        // Evaluated on next-cycle state/credit so fct_req lines up with rx_credit
        fct_req_d = is_link_state(state_d) && (credit_d <= CREDIT_REQ_LIMIT) &&
                    (fifo_free >= ({1'b0, credit_d} + {1'b0, FCT_CREDIT}));
    end

    always_ff @(posedge pclk_rx or negedge enable_rx) begin
        if (!enable_rx) begin
            state_q   <= WAIT_RUN;
            sync_q    <= 2'b00;
            data_q    <= 9'd0;
            write_q   <= 1'b0;
            fct_req_q <= 1'b0;
            credit_q  <= 6'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            data_q    <= data_d;
            write_q   <= write_d;
            fct_req_q <= fct_req_d;
            credit_q  <= credit_d;
            err_q     <= err_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rxwrite_rx   = write_q;
    assign fct_req      = fct_req_q;
    assign rx_credit    = credit_q;
    assign credit_error = err_q;

    rx_timecode_check u_tc (
        .pclk_rx       (pclk_rx),
        .enable_rx     (enable_rx),
        .time_en       (link_run),
        .rx_got_time   (rx_got_time),
        .rx_time       (rx_time),
        .timecode_rx_o (timecode_rx_o),
        .tickout_rx    (tickout_rx)
    );

endmodule
